spi_line_prefetch: RTL

- Parametrised successor to the single-buffer VGA SPI ROM line reader.
- Fetches one line of DATA_BITS bits from an SPI flash using READ (CMD, default 03h) at a caller-supplied address, shifting the line into a back buffer.
- A double buffer lets the display drain the previous line from a front buffer during the fetch. SCLK is generated internally by a divider; it is no longer tied to the inverted clk.
- Sits between vga_sync-derived timing logic and the flash pads.

---
 rtl/spi_line_prefetch_pkg.sv | 18 +
 rtl/spi_line_prefetch_sclk_gen.sv | 41 ++++
 rtl/spi_line_prefetch.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/spi_line_prefetch_pkg.sv
// rtl/spi_line_prefetch_pkg.sv - shared state encodings and opcode for the SPI line prefetcher
package spi_line_prefetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_GAP  = 3'd4
    } spi_state_e;

    localparam logic [7:0] SPI_CMD_READ = 8'h03;

    function automatic logic in_transfer(input spi_state_e s);
        return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/spi_line_prefetch_sclk_gen.sv
// rtl/spi_line_prefetch_sclk_gen.sv - SCLK divider with rise/fall strobes on the driving clk edge
module spi_line_prefetch_sclk_gen #(
    parameter int SCLK_DIV = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise_evt,
    output logic o_fall_evt
);

    localparam int CNT_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sclk;
    logic             w_half_done;

    // Strobes mark the clk edge that will flip sclk, so users act on that same edge.
    assign w_half_done = i_en && (r_cnt == CNT_LAST);
    assign o_rise_evt  = w_half_done && !r_sclk;
    assign o_fall_evt  = w_half_done && r_sclk;
    assign o_sclk      = r_sclk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (!i_en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_half_done) begin
            r_cnt  <= '0;
            r_sclk <= !r_sclk;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_line_prefetch.sv
// rtl/spi_line_prefetch.sv - double-buffered SPI flash line fetcher feeding a pixel shifter
module spi_line_prefetch
    import spi_line_prefetch_pkg::*;
#(
    parameter int         DATA_BITS = 128,
    parameter int         ADDR_W    = 24,
    parameter logic [7:0] CMD       = SPI_CMD_READ,
    parameter int         SCLK_DIV  = 1,
    parameter int         CS_GAP    = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_start,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_busy,
    output logic              fetch_done,
    input  logic              buf_swap,
    output logic              underrun,
    input  logic              pix_shift,
    output logic              pix_data,
    output logic              spi_cs,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int TX_W     = 8 + ADDR_W;
    localparam int MAX_BITS = (DATA_BITS > ADDR_W) ? DATA_BITS : ADDR_W;
    localparam int BIT_W    = $clog2(MAX_BITS);
    localparam int GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    spi_state_e           r_state;
    spi_state_e           w_state_nxt;
    logic [TX_W-1:0]      r_tx;
    logic [DATA_BITS-1:0] r_back;
    logic [DATA_BITS-1:0] r_front;
    logic [BIT_W-1:0]     r_bit;
    logic [GAP_W-1:0]     r_gap;
    logic                 r_cs;
    logic                 r_done;
    logic                 r_underrun;
    logic                 r_aborted;
    logic                 w_busy;
    logic                 w_xfer;
    logic                 w_swap_busy;
    logic                 w_sclk_en;
    logic                 w_accept;
    logic                 w_leave_xfer;
    logic                 w_sclk;
    logic                 w_rise;
    logic                 w_fall;

    assign w_busy       = (r_state != ST_IDLE);
    assign w_xfer       = in_transfer(r_state);
    assign w_swap_busy  = buf_swap && w_busy;
    assign w_sclk_en    = w_xfer && !w_swap_busy;
    assign w_accept     = (r_state == ST_IDLE) && fetch_start;
    assign w_leave_xfer = w_xfer && (w_state_nxt == ST_GAP);

    spi_line_prefetch_sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_en       (w_sclk_en),
        .o_sclk     (w_sclk),
        .o_rise_evt (w_rise),
        .o_fall_evt (w_fall)
    );

    // A swap during a transfer aborts it; the phase counters advance on sclk falls.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (fetch_start) w_state_nxt = ST_CMD;
            ST_CMD: begin
                if (w_swap_busy)                            w_state_nxt = ST_GAP;
                else if (w_fall && r_bit == BIT_W'(7))      w_state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                if (w_swap_busy)                            w_state_nxt = ST_GAP;
                else if (w_fall && r_bit == BIT_W'(ADDR_W - 1)) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_swap_busy)                            w_state_nxt = ST_GAP;
                else if (w_fall && r_bit == BIT_W'(DATA_BITS - 1)) w_state_nxt = ST_GAP;
            end
            ST_GAP: if (r_gap == GAP_W'(CS_GAP - 1)) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx       <= '0;
            r_back     <= '0;
            r_front    <= '0;
            r_bit      <= '0;
            r_gap      <= '0;
            r_cs       <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            r_aborted  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_underrun <= w_swap_busy;

            // Zero fill of the shift register keeps mosi low once the address is out.
            if (w_accept) begin
                r_tx      <= {CMD, fetch_addr};
                r_cs      <= 1'b1;
                r_aborted <= 1'b0;
            end else if (w_leave_xfer) begin
                r_tx      <= '0;
                r_cs      <= 1'b0;
            end else if (w_fall) begin
                r_tx      <= {r_tx[TX_W-2:0], 1'b0};
            end

            if (w_state_nxt != r_state) r_bit <= '0;
            else if (w_fall)            r_bit <= r_bit + 1'b1;

            if (r_state == ST_GAP && w_state_nxt == ST_GAP) r_gap <= r_gap + 1'b1;
            else                                            r_gap <= '0;

            if (w_swap_busy) r_aborted <= 1'b1;
            if (r_state == ST_GAP && w_state_nxt == ST_IDLE)
                r_done <= !(r_aborted || w_swap_busy);

            if (w_rise && r_state == ST_DATA)
                r_back <= {r_back[DATA_BITS-2:0], spi_miso};

            if (buf_swap)       r_front <= r_back;
            else if (pix_shift) r_front <= {r_front[DATA_BITS-2:0], 1'b0};
        end
    end

    assign fetch_busy = w_busy;
    assign fetch_done = r_done;
    assign underrun   = r_underrun;
    assign pix_data   = r_front[DATA_BITS-1];
    assign spi_cs     = r_cs;
    assign spi_sclk   = w_sclk;
    assign spi_mosi   = r_tx[TX_W-1];

endmodule
